// File: rtl/nextroute_table.sv
// nextroute_table: runtime-programmable next-hop route lookup.
// A route table of 2^DEST_W entries, each SEL_W bits wide, is loaded from
// ROUTE_INIT on reset and can be rewritten through the cfg_* port. Lookups
// go through a single registered valid/ready stage.
// Optional build macro NEXTROUTE_TABLE_STATS_EN adds a saturating
// accepted-lookup counter (stat_clr / stat_lookups).
module nextroute_table #(
  parameter int unsigned DEST_W = 4,
  parameter int unsigned SEL_W  = 1,
  parameter logic [(2**DEST_W)*SEL_W-1:0] ROUTE_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [DEST_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]  cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEST_W-1:0] in_dest,
`ifdef NEXTROUTE_TABLE_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_lookups,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_sel,
  output logic [DEST_W-1:0] out_dest
);

  localparam int unsigned DEPTH = 2**DEST_W;

  logic [SEL_W-1:0] tbl [DEPTH];
  logic             accept;
  logic [SEL_W-1:0] lookup_sel;

  // Handshake: the output stage can take a new request when empty or draining.
  always_comb begin
    in_ready = ~out_valid | out_ready;
    accept   = in_valid & in_ready;
  end

  // Lookup with write-through bypass when a same-cycle write hits the looked-up entry.
  always_comb begin
    lookup_sel = tbl[in_dest];
    if (cfg_we && (cfg_addr == in_dest)) begin
      lookup_sel = cfg_data;
    end
  end

  // Route table storage: reload from ROUTE_INIT on reset, otherwise accept config writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= ROUTE_INIT[i*SEL_W +: SEL_W];
      end
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Output stage: capture the result on accept, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_dest  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sel   <= lookup_sel;
      out_dest  <= in_dest;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NEXTROUTE_TABLE_STATS_EN
  // Saturating count of accepted lookups; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_lookups <= '0;
    end else if (accept && (stat_lookups != '1)) begin
      stat_lookups <= stat_lookups + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nextroute_table.sv
// tb_nextroute_table: self-checking bench for nextroute_table
// (DEST_W=4, SEL_W=2). Expected results are queued at accept time and
// compared as the DUT hands them downstream.
module tb_nextroute_table;

  localparam int unsigned DEST_W = 4;
  localparam int unsigned SEL_W  = 2;
  // entry i = i%4, except entry 5 = 3 and entry 7 = 0
  localparam logic [31:0] RINIT = 32'hE4E4_2CE4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [DEST_W-1:0] cfg_addr;
  logic [SEL_W-1:0]  cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_sel;
  logic [DEST_W-1:0] out_dest;
`ifdef NEXTROUTE_TABLE_STATS_EN
  logic              stat_clr;
  logic [15:0]       stat_lookups;
`endif

  nextroute_table #(.DEST_W(DEST_W), .SEL_W(SEL_W), .ROUTE_INIT(RINIT)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
`ifdef NEXTROUTE_TABLE_STATS_EN
    .stat_clr(stat_clr), .stat_lookups(stat_lookups),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_dest(out_dest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [SEL_W-1:0]  sel;
  } exp_t;

  typedef struct {
    logic [DEST_W-1:0] dest;
    logic              we;
    logic [DEST_W-1:0] addr;
    logic [SEL_W-1:0]  data;
    logic [SEL_W-1:0]  exp_sel;
  } vec_t;

  exp_t             exp_q[$];
  logic [SEL_W-1:0] ref_tbl [16];
  int               checks   = 0;
  int               failures = 0;
  bit               sb_en    = 1'b1;

  function automatic logic [SEL_W-1:0] init_sel(input int i);
    if (i == 5) return 2'd3;
    if (i == 7) return 2'd0;
    return 2'(i % 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic reset_ref();
    for (int i = 0; i < 16; i++) ref_tbl[i] = init_sel(i);
  endtask

  // Scoreboard: pop and compare each result as it is handed downstream.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      exp_q.delete();
    end else if (sb_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_dest), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_sel", 32'(out_sel), 32'(e.sel));
        check("out_dest", 32'(out_dest), 32'(e.dest));
      end
    end
  end

  // Drive one lookup (optionally with a config write in the same cycle) and
  // queue its expected result once it is seen to be accepted.
  task automatic lookup(input logic [DEST_W-1:0] d, input logic we,
                        input logic [DEST_W-1:0] a, input logic [SEL_W-1:0] wd,
                        input logic [SEL_W-1:0] exp_sel, input bit use_exp);
    int waited;
    exp_t e;
    in_valid = 1'b1; in_dest = d;
    cfg_we = we; cfg_addr = a; cfg_data = wd;
    waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      if (cfg_we) ref_tbl[a] = wd;
      cfg_we = 1'b0;
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.dest = d;
      if (use_exp) e.sel = exp_sel;
      else if (cfg_we && a == d) e.sel = wd;
      else e.sel = ref_tbl[d];
      exp_q.push_back(e);
    end
    if (cfg_we) ref_tbl[a] = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{dest: 4'd5,  we: 1'b0, addr: 4'd0,  data: 2'd0, exp_sel: 2'd3};
    vecs[1] = '{dest: 4'd4,  we: 1'b1, addr: 4'd3,  data: 2'd1, exp_sel: 2'd0};
    vecs[2] = '{dest: 4'd3,  we: 1'b0, addr: 4'd0,  data: 2'd0, exp_sel: 2'd1};
    vecs[3] = '{dest: 4'd7,  we: 1'b1, addr: 4'd7,  data: 2'd2, exp_sel: 2'd2};
    vecs[4] = '{dest: 4'd7,  we: 1'b0, addr: 4'd0,  data: 2'd0, exp_sel: 2'd2};
    vecs[5] = '{dest: 4'd0,  we: 1'b1, addr: 4'd0,  data: 2'd3, exp_sel: 2'd3};
    vecs[6] = '{dest: 4'd15, we: 1'b0, addr: 4'd0,  data: 2'd0, exp_sel: 2'd3};
    vecs[7] = '{dest: 4'd10, we: 1'b1, addr: 4'd11, data: 2'd0, exp_sel: 2'd2};
    vecs[8] = '{dest: 4'd11, we: 1'b0, addr: 4'd0,  data: 2'd0, exp_sel: 2'd0};

    reset_ref();
    // reset, with a write and a request that must be ignored
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 2'd0;
    in_valid = 1'b1; in_dest = 4'd1; out_ready = 1'b1;
`ifdef NEXTROUTE_TABLE_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_out_dest", 32'(out_dest), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef NEXTROUTE_TABLE_STATS_EN
    check("rst_stat", 32'(stat_lookups), 32'd0);
`endif

    // table-driven lookups: init, reprogram, collision bypass
    for (int i = 0; i < 9; i++) begin
      lookup(vecs[i].dest, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_sel, 1'b1);
    end
    @(posedge clk); #1;

    // backpressure: hold result for dest 2, write entry 2 during stall
    lookup(4'd2, 1'b0, 4'd0, 2'd0, 2'd2, 1'b1);
    out_ready = 1'b0; in_valid = 1'b1; in_dest = 4'd9;
    for (int k = 0; k < 5; k++) begin
      cfg_we = (k == 1); cfg_addr = 4'd2; cfg_data = 2'd1;
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_sel", 32'(out_sel), 32'd2);
      check("stall_out_dest", 32'(out_dest), 32'd2);
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    ref_tbl[2] = 2'd1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{dest: 4'd9, sel: 2'd1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lookup(4'd2, 1'b0, 4'd0, 2'd0, 2'd1, 1'b1);

    // streaming 0..15 with no bubbles
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      in_valid = 1'b1; in_dest = 4'(i);
      @(negedge clk);
      if (i > 0) check("stream_out_valid", 32'(out_valid), 32'd1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      e.dest = 4'(i); e.sel = ref_tbl[i];
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

`ifdef NEXTROUTE_TABLE_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) lookup(4'(i + 1), 1'b0, 4'd0, 2'd0, 2'd0, 1'b0);
    check("stat_three", 32'(stat_lookups), 32'd3);
`endif

    // mid-operation reset discards a held result and restores ROUTE_INIT
    out_ready = 1'b0;
    lookup(4'd6, 1'b0, 4'd0, 2'd0, 2'd2, 1'b1);
    check("held_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_ref();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sel", 32'(out_sel), 32'd0);
    check("midrst_out_dest", 32'(out_dest), 32'd0);
`ifdef NEXTROUTE_TABLE_STATS_EN
    check("midrst_stat", 32'(stat_lookups), 32'd0);
`endif
    out_ready = 1'b1;
    lookup(4'd3, 1'b0, 4'd0, 2'd0, 2'd3, 1'b1);
    lookup(4'd2, 1'b0, 4'd0, 2'd0, 2'd2, 1'b1);
    lookup(4'd7, 1'b0, 4'd0, 2'd0, 2'd0, 1'b1);
    @(posedge clk); #1;

`ifdef NEXTROUTE_TABLE_STATS_EN
    // saturation and clear priority
    sb_en = 1'b0;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    in_valid = 1'b1; in_dest = 4'd1;
    repeat (65535) @(posedge clk);
    #1;
    check("stat_full", 32'(stat_lookups), 32'h0000_FFFF);
    @(posedge clk); #1;
    check("stat_saturate", 32'(stat_lookups), 32'h0000_FFFF);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0; in_valid = 1'b0;
    check("stat_clr_priority", 32'(stat_lookups), 32'd0);
    @(posedge clk); #1;
    sb_en = 1'b1;
`endif

    // drain the scoreboard
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
